module_display_mux: RTL and testbench
=====================================

// Module: module_display_mux
// PURPOSE
//  Time-multiplexed driver for the 4-digit common-anode 7-segment display; sits downstream of the
//  segment-encoding stage. Captures four 7-bit digit patterns on the 'listo' strobe into shadow
//  registers and commits them only at frame boundaries (tear-free). Scans one digit per slot,
//  with a blanking gap before each slot to suppress ghosting.
// PARAMETERS
//  CLK_HZ          27_000_000  input clock frequency
//  REFRESH_HZ      250         full 4-digit frame rate
//  BLANK_CYCLES    64          cycles per slot with all anodes off, at slot start
//  SEG_ACTIVE_LOW  1           1: seg_out bit=0 lights segment
//  AN_ACTIVE_LOW   1           1: anodo bit=0 enables digit
//  Derived: SLOT = CLK_HZ/(4*REFRESH_HZ); elaboration error unless SLOT > BLANK_CYCLES+1
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-high
//  listo          in   1  1-cycle strobe: digit patterns valid this cycle
//  seg_unidades   in   7  digit 0 pattern, bit=1 lit, [6:0]=g..a
//  seg_decenas    in   7  digit 1 pattern
//  seg_centenas   in   7  digit 2 pattern
//  seg_milesimas  in   7  digit 3 pattern
//  blank_mask     in   4  bit i=1 forces digit i dark; captured with listo
//  seg_out        out  7  shared segment bus, polarity per SEG_ACTIVE_LOW
//  anodo          out  4  one-hot digit enables, polarity per AN_ACTIVE_LOW
//  frame_start    out  1  1-cycle pulse at first cycle of digit-0 slot
// BEHAVIOUR
//  Reset: all anodes inactive; seg_out = all segments off; frame_start=0; digit index=0;
//   slot counter=0; state=S_BLANK; shadow, active regs and mask cleared (all digits dark);
//   pending=0. Reset mid-frame aborts the scan immediately.
//  Capture: listo=1 -> shadow <= inputs+mask, pending<=1 (same edge). Further strobes before
//   commit overwrite shadow; last wins. No strobe is ever lost in value, only superseded.
//  Commit: at the boundary entering digit-0 slot, if pending: active <= shadow, pending<=0.
//   listo in the same cycle as the boundary: strobed inputs bypass shadow into active; that
//   frame shows the new data, pending ends 0.
//  Timing: slot counter 0..SLOT-1; wraps -> digit index (0->1->2->3->0), state back to S_BLANK.
//  FSM: S_BLANK (cnt < BLANK_CYCLES): anodes inactive, seg_out off.
//       S_ON (cnt >= BLANK_CYCLES): anodo asserts current digit; seg_out = active pattern,
//        or all off if active mask bit set.
//  Outputs registered: one cycle latency from counter/state to pins.
//  frame_start asserts in the cycle the registered outputs begin digit-0 S_BLANK.
//  Never more than one anode active; anodes never change in the same cycle as seg_out
//   transitions from one digit's data to the next (guaranteed by blank gap).
// STRUCTURE
//  Package display_pkg: typedef logic[6:0] seg_t; typedef logic[1:0] digit_idx_t;
//   enum {S_BLANK,S_ON} scan_state_t; SEG_OFF constant.
//  Sub-module module_refresh_timer: slot counter + digit index; emits slot_tick, frame_tick,
//   in_blank. Top of block: shadow/active registers, commit logic, output encode.
// TESTING (CLK_HZ=800, REFRESH_HZ=10 -> SLOT=20, BLANK_CYCLES=4)
//  Reset release, no listo -> anodo=4'b1111, seg_out=7'h7F for 200 cycles; frame_start every 80.
//  listo with 7'h06/7'h5B/7'h4F/7'h66, mask 0 -> next frame: each digit low for 16 cycles after
//   4 blank cycles, seg_out=~pattern; anodo sequence 1110,1101,1011,0111.
//  listo with 7'h3F then listo with 7'h7F mid-frame -> current frame unchanged; next frame
//   shows only 7'h7F data.
//  listo coincident with frame boundary -> that frame displays new data; no extra frame delay.
//  blank_mask=4'b1000 -> digit 3 slot: anodo active-low bit3=0 but seg_out=7'h7F.
//  Assert rst mid S_ON of digit 2 -> same cycle anodo=1111; after release, scan restarts at
//   digit 0, display dark until next listo.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and polarity helpers for the 4-digit 7-segment scan driver.
package display_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;
  typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} scan_state_t;

  localparam int   NUM_DIGITS = 4;
  localparam seg_t SEG_OFF    = 7'h00;

  function automatic seg_t seg_to_pin(input seg_t s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

  function automatic logic [3:0] an_to_pin(input logic [3:0] onehot, input logic active_low);
    return active_low ? ~onehot : onehot;
  endfunction
endpackage

// File: rtl/module_refresh_timer.sv
// Slot counter and digit index for the display scan; the blank/on phase of
// each slot is tracked as a registered state that always follows the counter.
module module_refresh_timer
  import display_pkg::*;
#(
  parameter int SLOT         = 20,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] digit_o,
  output logic       slot_start_o,
  output logic       frame_tick_o,
  output logic       in_blank_o
);
  localparam int CNT_W = $clog2(SLOT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       digit_q, digit_d;
  scan_state_t      state_q, state_d;
  logic             slot_tick;

  always_comb begin
    slot_tick = (cnt_q == CNT_LAST);
    cnt_d     = slot_tick ? '0 : cnt_q + CNT_W'(1);
    digit_d   = slot_tick ? digit_q + 2'd1 : digit_q;
    state_d   = (cnt_d < BLANK_CNT) ? S_BLANK : S_ON;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
      state_q <= S_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  assign digit_o      = digit_q;
  assign slot_start_o = (cnt_q == '0);
  assign frame_tick_o = slot_tick && (digit_q == 2'd3);
  assign in_blank_o   = (state_q == S_BLANK);
endmodule

// File: rtl/module_display_mux.sv
// Time-multiplexed 4-digit 7-segment driver: strobed patterns are held in a
// shadow bank and committed at frame boundaries so a frame never tears.
module module_display_mux
  import display_pkg::*;
#(
  parameter int CLK_HZ         = 27_000_000,
  parameter int REFRESH_HZ     = 250,
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       listo,
  input  logic [6:0] seg_unidades,
  input  logic [6:0] seg_decenas,
  input  logic [6:0] seg_centenas,
  input  logic [6:0] seg_milesimas,
  input  logic [3:0] blank_mask,
  output logic [6:0] seg_out,
  output logic [3:0] anodo,
  output logic       frame_start
);
  localparam int         SLOT        = CLK_HZ / (4 * REFRESH_HZ);
  localparam seg_t       SEG_OFF_PIN = seg_to_pin(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic [3:0] AN_OFF_PIN  = an_to_pin(4'b0000, AN_ACTIVE_LOW);

  generate
    if (SLOT <= BLANK_CYCLES + 1) begin : g_bad_timing
      $error("module_display_mux: slot length %0d must exceed BLANK_CYCLES+1", SLOT);
    end
  endgenerate

  logic [1:0] digit;
  logic       slot_start, frame_tick, in_blank;

  module_refresh_timer #(
    .SLOT        (SLOT),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .digit_o     (digit),
    .slot_start_o(slot_start),
    .frame_tick_o(frame_tick),
    .in_blank_o  (in_blank)
  );

  seg_t in_seg [NUM_DIGITS];
  assign in_seg[0] = seg_unidades;
  assign in_seg[1] = seg_decenas;
  assign in_seg[2] = seg_centenas;
  assign in_seg[3] = seg_milesimas;

  seg_t       shadow_q [NUM_DIGITS];
  seg_t       shadow_d [NUM_DIGITS];
  seg_t       active_q [NUM_DIGITS];
  seg_t       active_d [NUM_DIGITS];
  logic [3:0] shadow_mask_q, shadow_mask_d;
  logic [3:0] active_mask_q, active_mask_d;
  logic       pending_q, pending_d;
  logic       valid_q, valid_d;
  seg_t       seg_out_q, seg_out_d;
  logic [3:0] anodo_q, anodo_d;
  logic       frame_start_q, frame_start_d;

  // Capture and commit. A strobe landing on the boundary cycle goes straight
  // into the active bank so that frame already shows it.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_mask_d = shadow_mask_q;
    active_d      = active_q;
    active_mask_d = active_mask_q;
    valid_d       = valid_q;
    pending_d     = pending_q | listo;
    if (listo) begin
      shadow_d      = in_seg;
      shadow_mask_d = blank_mask;
    end
    if (frame_tick) begin
      if (listo) begin
        active_d      = in_seg;
        active_mask_d = blank_mask;
        valid_d       = 1'b1;
      end else if (pending_q) begin
        active_d      = shadow_q;
        active_mask_d = shadow_mask_q;
        valid_d       = 1'b1;
      end
      pending_d = 1'b0;
    end
  end

  // Until the first commit after reset nothing has been loaded, so the whole
  // display stays dark with every anode off rather than lighting empty digits.
  always_comb begin
    frame_start_d = slot_start && (digit == 2'd0);
    anodo_d       = AN_OFF_PIN;
    seg_out_d     = SEG_OFF_PIN;
    if (!in_blank && valid_q) begin
      anodo_d   = an_to_pin(4'b0001 << digit, AN_ACTIVE_LOW);
      seg_out_d = active_mask_q[digit] ? SEG_OFF_PIN
                                       : seg_to_pin(active_q[digit], SEG_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '{default: SEG_OFF};
      active_q      <= '{default: SEG_OFF};
      shadow_mask_q <= 4'hF;
      active_mask_q <= 4'hF;
      pending_q     <= 1'b0;
      valid_q       <= 1'b0;
      seg_out_q     <= SEG_OFF_PIN;
      anodo_q       <= AN_OFF_PIN;
      frame_start_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_mask_q <= shadow_mask_d;
      active_mask_q <= active_mask_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      seg_out_q     <= seg_out_d;
      anodo_q       <= anodo_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_out_q;
  assign anodo       = anodo_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_module_display_mux.sv
// Randomized bench for module_display_mux; expected pins come from a frame-level
// model: frame f shows the newest strobe taken on or before its opening edge.
module tb_module_display_mux;
  localparam int SLOT  = 20;
  localparam int BLANK = 4;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       listo = 1'b0;
  logic [6:0] seg_unidades = '0, seg_decenas = '0, seg_centenas = '0, seg_milesimas = '0;
  logic [3:0] blank_mask = '0;
  logic [6:0] seg_out;
  logic [3:0] anodo;
  logic       frame_start;

  module_display_mux #(
    .CLK_HZ(800), .REFRESH_HZ(10), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .listo(listo),
    .seg_unidades(seg_unidades), .seg_decenas(seg_decenas),
    .seg_centenas(seg_centenas), .seg_milesimas(seg_milesimas),
    .blank_mask(blank_mask), .seg_out(seg_out), .anodo(anodo),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic [27:0] pats;
    logic [3:0]  mask;
  } strobe_t;

  strobe_t hist[$];
  int      k = 0;       // clock edges since reset release
  int      errors = 0;
  int      checks = 0;

  // Expected pins after edge k: edge k shows scan position k-1.
  function automatic void model(output logic [6:0] es, output logic [3:0] ea, output logic efs);
    int p, f, d, c;
    bit found;
    logic [27:0] pats;
    logic [3:0]  m;
    es = 7'h7F; ea = 4'hF; efs = 1'b0;
    pats = '0; m = '0; found = 0;
    if (k == 0) return;
    p = k - 1;
    f = p / FRAME;
    d = (p / SLOT) % 4;
    c = p % SLOT;
    efs = (p % FRAME == 0);
    foreach (hist[i]) begin
      if (hist[i].edge_n <= f * FRAME) begin
        found = 1; pats = hist[i].pats; m = hist[i].mask;
      end
    end
    if (found && c >= BLANK) begin
      ea = ~(4'b0001 << d);
      es = m[d] ? 7'h7F : ~pats[7*d +: 7];
    end
  endfunction

  task automatic tick(input bit l, input logic [27:0] pats, input logic [3:0] m);
    listo = l;
    seg_unidades = pats[6:0];   seg_decenas   = pats[13:7];
    seg_centenas = pats[20:14]; seg_milesimas = pats[27:21];
    blank_mask = m;
    @(posedge clk);
    k++;
    if (l) hist.push_back('{edge_n: k, pats: pats, mask: m});
    #1;
    listo = 1'b0;
  endtask

  function automatic logic [27:0] rnd_pats();
    return 28'($urandom);
  endfunction

  task automatic test_reset();
    logic [6:0] es; logic [3:0] ea; logic efs;
    int fs_cnt = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (anodo !== 4'hF || seg_out !== 7'h7F || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state anodo=%b seg_out=%h fs=%b required 1111/7f/0", anodo, seg_out, frame_start);
    end
    @(negedge clk); rst = 1'b0; k = 0; hist.delete();
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      if (frame_start === 1'b1) fs_cnt++;
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs) begin
        errors++;
        $display("FAIL reset_idle k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
    checks++;
    if (fs_cnt !== 3) begin
      errors++;
      $display("FAIL frame_start_count got=%0d required=3", fs_cnt);
    end
  endtask

  task automatic test_patterns();
    logic [6:0] es; logic [3:0] ea; logic efs;
    logic [27:0] p = {7'h66, 7'h4F, 7'h5B, 7'h06};
    for (int i = 0; i < 200; i++) begin
      if (i == 3) tick(1'b1, p, 4'b0000);
      else tick(1'b0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
        errors++;
        $display("FAIL patterns k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
  endtask

  task automatic test_supersede();
    logic [6:0] es; logic [3:0] ea; logic efs;
    for (int i = 0; i < 200; i++) begin
      if (i == 5)       tick(1'b1, {4{7'h3F}}, 4'b0000);
      else if (i == 30) tick(1'b1, {4{7'h7F}}, 4'b0000);
      else              tick(1'b0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
        errors++;
        $display("FAIL supersede k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
  endtask

  task automatic test_boundary();
    logic [6:0] es; logic [3:0] ea; logic efs;
    int n_idle;
    for (int r = 0; r < 2; r++) begin
      n_idle = (FRAME - ((k + 1) % FRAME)) % FRAME;
      for (int i = 0; i < n_idle + 100; i++) begin
        if (i == n_idle) tick(1'b1, rnd_pats(), 4'b0000);
        else tick(1'b0, rnd_pats(), 4'($urandom));
        model(es, ea, efs);
        checks++;
        if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
          errors++;
          $display("FAIL boundary k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [6:0] es; logic [3:0] ea; logic efs;
    for (int i = 0; i < 200; i++) begin
      if (i == 10) tick(1'b1, rnd_pats(), 4'b1000);
      else tick(1'b0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
        errors++;
        $display("FAIL mask k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] es; logic [3:0] ea; logic efs;
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 39) == 0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
        errors++;
        $display("FAIL random k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] es; logic [3:0] ea; logic efs;
    tick(1'b1, {4{7'h49}}, 4'b0000);
    for (int i = 0; i < 3 * FRAME && !(k > FRAME && (k - 1) % FRAME == 2 * SLOT + 10); i++)
      tick(1'b0, rnd_pats(), 4'($urandom));
    checks++;
    if (anodo !== 4'b1011) begin
      errors++;
      $display("FAIL reset_mid_pre anodo=%b required=1011", anodo);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (anodo !== 4'hF || seg_out !== 7'h7F || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async anodo=%b seg_out=%h fs=%b required 1111/7f/0", anodo, seg_out, frame_start);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; k = 0; hist.delete();
    for (int i = 0; i < 260; i++) begin
      if (i == 200) tick(1'b1, rnd_pats(), 4'($urandom));
      else tick(1'b0, rnd_pats(), 4'($urandom));
      model(es, ea, efs);
      checks++;
      if (seg_out !== es || anodo !== ea || frame_start !== efs || $countones(~anodo) > 1) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d seg=%h exp=%h an=%b exp=%b fs=%b exp=%b", k, seg_out, es, anodo, ea, frame_start, efs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_supersede();
    test_boundary();
    test_mask();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
